// File: rtl/inv_witness_bvlshr_pkg.sv
// Shared types for the logical-shift-right invertibility witness engine.
package inv_witness_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        SLE = 2'd0,
        SLT = 2'd1,
        ULE = 2'd2,
        ULT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/inv_witness_bvlshr_pred_eval.sv
// Combinational predicate (x >> s) <mode> t; shifts of WIDTH or more yield zero.
module inv_pred_eval
    import inv_witness_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    input  mode_e            mode,
    output logic             hit
);

    logic [WIDTH-1:0] y;

    always_comb begin
        y = '0;
        if (32'(s) < 32'(WIDTH)) begin
            y = x >> s;
        end
    end

    always_comb begin
        hit = 1'b0;
        unique case (mode)
            SLE: hit = ($signed(y) <= $signed(t));
            SLT: hit = ($signed(y) <  $signed(t));
            ULE: hit = (y <= t);
            ULT: hit = (y <  t);
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/inv_witness_bvlshr.sv
// Minimum-x witness engine for (x >> s) <op> t with valid/ready request and response.
// Optional build macro INV_WITNESS_FASTPATH_EN replaces the sweep with a closed form.
module inv_witness_bvlshr
    import inv_witness_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [MODE_W-1:0] req_mode,
    input  logic [WIDTH-1:0]  req_s,
    input  logic [WIDTH-1:0]  req_t,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_found,
    output logic [WIDTH-1:0]  resp_x,
    output logic [WIDTH:0]    resp_cycles
);

    localparam logic [WIDTH:0] ONE_W1 = {{WIDTH{1'b0}}, 1'b1};

    state_e           state, state_d;
    mode_e            mode_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] t_q;

`ifdef INV_WITNESS_FASTPATH_EN
    localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

    logic             fast_found;
    logic [WIDTH-1:0] fast_x;

    // Shifted value is non-negative unless s = 0, so only then can a negative bound be met (by MIN).
    always_comb begin
        fast_found = 1'b0;
        fast_x     = '0;
        unique case (mode_q)
            SLE: begin
                if (!t_q[WIDTH-1]) begin
                    fast_found = 1'b1;
                end else if (s_q == '0) begin
                    fast_found = 1'b1;
                    fast_x     = MIN_S;
                end
            end
            SLT: begin
                if (!t_q[WIDTH-1] && (t_q != '0)) begin
                    fast_found = 1'b1;
                end else if ((s_q == '0) && (t_q != MIN_S)) begin
                    fast_found = 1'b1;
                    fast_x     = MIN_S;
                end
            end
            ULE: fast_found = 1'b1;
            ULT: fast_found = (t_q != '0);
            default: fast_found = 1'b0;
        endcase
    end

    logic search_end;
    assign search_end = 1'b1;
`else
    logic [WIDTH:0] cand;
    logic           hit;
    logic           last;
    logic           search_end;

    inv_pred_eval #(.WIDTH(WIDTH)) u_pred (
        .x    (cand[WIDTH-1:0]),
        .s    (s_q),
        .t    (t_q),
        .mode (mode_q),
        .hit  (hit)
    );

    assign last       = (cand == {1'b0, {WIDTH{1'b1}}});
    assign search_end = hit || last;
`endif

    always_comb begin
        state_d    = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (search_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= SLE;
            s_q         <= '0;
            t_q         <= '0;
            resp_found  <= 1'b0;
            resp_x      <= '0;
            resp_cycles <= '0;
`ifndef INV_WITNESS_FASTPATH_EN
            cand        <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        mode_q      <= mode_e'(req_mode);
                        s_q         <= req_s;
                        t_q         <= req_t;
                        resp_found  <= 1'b0;
                        resp_x      <= '0;
                        resp_cycles <= '0;
`ifndef INV_WITNESS_FASTPATH_EN
                        cand        <= '0;
`endif
                    end
                end
                SEARCH: begin
`ifdef INV_WITNESS_FASTPATH_EN
                    resp_found  <= fast_found;
                    resp_x      <= fast_x;
                    resp_cycles <= ONE_W1;
`else
                    resp_cycles <= resp_cycles + ONE_W1;
                    if (hit) begin
                        resp_found <= 1'b1;
                        resp_x     <= cand[WIDTH-1:0];
                    end else if (last) begin
                        resp_found <= 1'b0;
                        resp_x     <= '0;
                    end else begin
                        cand <= cand + ONE_W1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/inv_witness_bvlshr.md
# inv_witness_bvlshr

Parametrised sequential Skolem-witness engine for the invertibility conditions of `(x >> s) <op> t`, where `>>` is logical shift right. Given `s` and `t`, it returns the smallest unsigned `x` that satisfies the predicate, or reports that no such `x` exists. It generalises the fixed 4-bit signed-less-or-equal combinational witness in three ways: `WIDTH` is a parameter, four comparison modes are supported, and requests use a valid/ready handshake. It sits behind the solver front-end as a request/response slave.

## Interface
- `WIDTH`, default 4: bit width of `s`, `t` and `x`. Legal range is 2..16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  engine can accept a request.
- `req_mode`  in  2  predicate select: 0 = `sle`, 1 = `slt`, 2 = `ule`, 3 = `ult`.
- `req_s`  in  WIDTH  shift amount, unsigned.
- `req_t`  in  WIDTH  comparison bound.
- `resp_valid`  out  1  result present.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_found`  out  1  a witness exists.
- `resp_x`  out  WIDTH  witness; 0 when `resp_found` = 0.
- `resp_cycles`  out  WIDTH+1  number of SEARCH cycles spent on the request.

## Operation
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - `req_ready` = 1.
  - When `req_valid` and `req_ready` are both high, latch mode/s/t, clear candidate `cand` and `resp_cycles` to 0, then go to SEARCH.
- SEARCH, once per cycle:
  - Evaluate `y = cand >> s`. `y` = 0 when `s` >= WIDTH.
  - Compare `y` against `t` using the latched mode. Signed modes compare in two's complement.
  - `resp_cycles` increments every SEARCH cycle.
  - On a hit: `resp_found` = 1, `resp_x` = `cand`, go to DONE.
  - On a miss with `cand` = 2^WIDTH-1: `resp_found` = 0, `resp_x` = 0, go to DONE.
  - Otherwise `cand` increments.
  - `cand` is WIDTH+1 bits so the last check is free of wrap-around.
- DONE:
  - `resp_valid` = 1.
  - All `resp_*` outputs are held stable while `resp_ready` = 0.
  - When `resp_ready` = 1, go to IDLE.
- `req_ready` = 0 in SEARCH and DONE, so only one request is in flight.
- The sweep order is ascending unsigned, so the result is deterministic: the minimum-value witness.
- Reference results (MIN = 1 followed by WIDTH-1 zeros):
  - `sle`: if `t` >= 0 signed, x = 0. Else if `s` = 0, x = MIN. Else no witness.
  - `slt`: if `t` > 0, x = 0. Else if `s` = 0 and `t` != MIN, x = MIN. Else no witness.
  - `ule`: x = 0, always.
  - `ult`: if `t` != 0, x = 0. Else no witness.

## Timing
- Reset values: FSM = IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_found` = 0, `resp_x` = 0, `resp_cycles` = 0.
- Request accepted at edge N → SEARCH from cycle N+1.
- A hit on candidate k reaches DONE after k+1 SEARCH cycles. `resp_valid` rises on the edge after that SEARCH cycle.
- A miss takes 2^WIDTH SEARCH cycles.
- Minimum accept-to-`resp_valid` latency is 2 edges.
- Response consumed at edge M → `req_ready` = 1 in cycle M+1. No accept is possible in the same cycle as the response handshake.
- `rst_n` low in any state, including mid-SEARCH or DONE, returns the block to reset values on the next edge. The in-flight request is dropped.

## Configuration
- `INV_WITNESS_FASTPATH_EN` defined:
  - SEARCH lasts exactly 1 cycle.
  - `resp_found`/`resp_x` are computed from the closed-form reference results above.
  - `resp_cycles` = 1.
  - Results are bit-identical to the sweep.
- Undefined: full ascending sweep as described in Operation.
- Either way, the handshake and state sequence are unchanged.

## Structure
- Package `inv_witness_pkg` holds:
  - `mode_e` (SLE, SLT, ULE, ULT);
  - `state_e` (IDLE, SEARCH, DONE);
  - constant `MODE_W` = 2.
- Sub-module `inv_pred_eval`:
  - combinational;
  - parameter `WIDTH`;
  - inputs `x`, `s`, `t`, `mode`; output `hit`.
  - Used by the sweep datapath. The bench uses it as a reference model.

## Test plan
All scenarios use WIDTH = 4.
- `sle`, s = 0001, t = 0011 → found = 1, x = 0000, cycles = 1.
- `sle`, s = 0000, t = 1110 → found = 1, x = 1000. Sweep: cycles = 9. Fastpath: cycles = 1.
- `sle`, s = 0010, t = 1111 → found = 0, x = 0000. Sweep: cycles = 16. Same result for s = 0101 (s >= WIDTH).
- `ult`, t = 0000 → found = 0. `ule`, t = 0000 → found = 1, x = 0000. `slt`, s = 0000, t = 1000 → found = 0.
- Hold `resp_ready` = 0 for 5 cycles in DONE → `resp_valid`/`resp_x`/`resp_cycles` stable and `req_ready` = 0. A `req_valid` pulse during this time is ignored.
- Drive `rst_n` low in the 4th SEARCH cycle of a 16-cycle miss → next edge: IDLE, `resp_valid` = 0, `req_ready` = 1. A new request completes normally afterwards.
